uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Transmit-side UART framer that consumes the tx baud tick from the baud generator and serialises one parallel word per frame onto the `tx` line. Each frame has a start bit, LSB-first data, optional parity and 1 or 2 stop bits. It sits directly downstream of the baud generator: its `baud_tick` input is wired to the generator's tx tick output, which is one `clk`-wide pulse per bit period. Parallel data arrives through a valid/ready handshake from the host-side logic.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.
- `clk`, input, 1: system clock. Single clock domain.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `baud_tick`, input, 1: one-cycle bit-period strobe from the baud generator's tx tick.
- `tx_data`, input, `DATA_BITS`: word to send; sampled only on handshake.
- `tx_valid`, input, 1: `tx_data` is valid.
- `tx_ready`, output, 1: block can accept a word.
- `tx`, output, 1: serial line; idle high.
- `tx_busy`, output, 1: a frame is pending or in progress.
- `tx_done`, output, 1: one-cycle pulse when the last stop bit completes.

## Operation
- Handshake: a word is accepted on a `clk` edge where `tx_valid`=1 and `tx_ready`=1.
  - On accept, `tx_data` is latched into the shift register.
  - Parity is computed from the latched word: XOR of all data bits, XOR `PARITY_ODD`.
- `tx_ready`=1 only in IDLE. `tx_busy` = NOT `tx_ready`.
- States:
  - IDLE: `tx`=1. On accept → ARM.
  - ARM: `tx`=1. On `baud_tick` → START.
  - START: `tx`=0. On `baud_tick` → DATA, bit counter=0.
  - DATA: `tx`=shreg[0]. On `baud_tick`, shift right and increment the counter. When the counter reaches `DATA_BITS`-1 on a tick → PARITY if `PARITY_EN`, else STOP.
  - PARITY: `tx`=parity bit. On `baud_tick` → STOP, stop counter=0.
  - STOP: `tx`=1. On `baud_tick`:
    - If stop counter = `STOP_BITS`-1 → IDLE, and `tx_done` pulses.
    - Otherwise increment the stop counter.
- `baud_tick` is ignored in IDLE.
- Frame length is 1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS` bit periods, exclusive of the ARM wait.
- Bit counter is 4 bits wide and never wraps. Stop counter is 1 bit.
- `tx_data` changes while busy have no effect.
- Out-of-range parameter values are unsupported and are not checked in RTL.

## Timing
- Reset state (asynchronous, immediate on `reset_n` low):
  - `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
  - State IDLE, shift register and counters cleared.
- Reset mid-frame abandons the frame. `tx` returns high in the same instant, with no glitch low.
- All outputs are registered. Each `tx` bit value appears the cycle after the `baud_tick` that begins it and holds for exactly one tick interval.
- Accept latency: `tx_ready` drops the cycle after accept. A `baud_tick` in the accept cycle itself does not advance the FSM.
- Start-bit latency: `tx` falls the cycle after the first `baud_tick` that occurs strictly after the accept cycle.
- `tx_done` is high for the single cycle after the final stop tick. In that same cycle `tx_ready`=1.
- Back-to-back frames:
  - A new word can be accepted in the cycle `tx_done` is high.
  - Its start bit begins after the next tick, so there is no extra idle bit beyond the stop bits.
- `baud_tick` held high continuously advances one bit per `clk`. This is legal; used for fast simulation.

## Test plan
- Reset and idle:
  - Stimulus: assert `reset_n`=0 mid-DATA of a 0xA5 frame, then release.
  - Required: `tx`=1, `tx_ready`=1, `tx_busy`=0 immediately. No further line activity until the next accept.
- Basic frame:
  - Stimulus: 8N1, send 0xA5, tick every 16 clk.
  - Required: line bits 0,1,0,1,0,0,1,0,1,1. Each bit lasts 16 clk. `tx_done` pulses once, 16 clk after the stop bit starts.
- Parity:
  - Stimulus: `PARITY_EN`=1, even, send 0xA5; then odd, send 0x07.
  - Required: parity bit 0 for 0xA5; parity bit 0 for 0x07 (three ones, odd parity). Frame is 11 bits.
- Two stop bits and `DATA_BITS`=5:
  - Stimulus: send 5'h13.
  - Required: bits 0,1,1,0,0,1,1,1. `tx_done` asserts only after the second stop bit.
- Back-to-back with coincident tick:
  - Stimulus: hold `tx_valid` with 0x55 then 0xAA, with a tick in the accept cycle.
  - Required: that tick is ignored; the start bit follows the next tick. No idle gap between frames beyond the stop bit. `tx_ready` is low throughout each frame.
- Handshake stall:
  - Stimulus: `tx_valid`=0 for 100 ticks, then drive 0x3C.
  - Required: `tx` stays 1 through the stall. 0x3C is accepted in the first valid cycle, and its data is latched at that edge.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: transmit-side UART framer.
// Serialises one parallel word per frame (start, LSB-first data, optional
// parity, 1 or 2 stop bits) at the rate of the incoming baud_tick strobe.
// All outputs are registered: the next-state logic also computes the next
// output values, which are captured on the same edge as the state.
module uart_tx_serializer #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } state_t;

   localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic       ODD       = 1'(PARITY_ODD);
   localparam logic       HAS_PAR   = (PARITY_EN != 0);

   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [3:0]           bcnt_q,  bcnt_d;
   logic                 scnt_q,  scnt_d;
   logic                 par_q,   par_d;
   logic                 tx_d, ready_d, done_d;

   // Frame sequencing. tx_ready is high exactly when the FSM is in IDLE, so
   // the accept condition reduces to IDLE && tx_valid. baud_tick is not
   // looked at in IDLE, which is what makes a tick coinciding with the accept
   // edge fall into the ARM wait instead of starting the frame early.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bcnt_d  = bcnt_q;
      scnt_d  = scnt_q;
      par_d   = par_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               shreg_d = tx_data;
               par_d   = (^tx_data) ^ ODD;
               bcnt_d  = 4'd0;
               scnt_d  = 1'b0;
               state_d = ARM;
            end
         end
         ARM: begin
            if (baud_tick) state_d = START;
         end
         START: begin
            if (baud_tick) begin
               bcnt_d  = 4'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_tick) begin
               shreg_d = shreg_q >> 1;
               if (bcnt_q == LAST_BIT) begin
                  // counter parks at its last value; it is reloaded on accept
                  scnt_d  = 1'b0;
                  state_d = HAS_PAR ? PARITY : STOP;
               end else begin
                  bcnt_d = bcnt_q + 4'd1;
               end
            end
         end
         PARITY: begin
            if (baud_tick) begin
               scnt_d  = 1'b0;
               state_d = STOP;
            end
         end
         STOP: begin
            if (baud_tick) begin
               if (scnt_q == LAST_STOP) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level for the state being entered, so the registered tx changes on
   // the same edge as the state.
   always_comb begin
      tx_d    = 1'b1;
      ready_d = (state_d == IDLE);
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
   end

   // State, datapath and output registers; reset forces the line high at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bcnt_q   <= 4'd0;
         scnt_q   <= 1'b0;
         par_q    <= 1'b0;
         tx       <= 1'b1;
         tx_ready <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bcnt_q   <= bcnt_d;
         scnt_q   <= scnt_d;
         par_q    <= par_d;
         tx       <= tx_d;
         tx_ready <= ready_d;
         tx_busy  <= ~ready_d;
         tx_done  <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 5N2) share
// clock, reset and baud tick. Stimulus pushes the expected frame to a
// scoreboard; a line monitor pops it when a start bit appears and checks
// every bit on its first and last cycle plus the handshake outputs.
module tb_uart_tx_serializer;

   typedef struct {
      int          idx;
      logic [15:0] bits;
      int          n;
   } frame_t;

   logic       clk;
   logic       reset_n;
   logic       baud_tick;
   logic [3:0] vld;
   logic [7:0] d0, d1, d2;
   logic [4:0] d3;
   logic [3:0] txl, rdy, bsy, dne;

   int     P = 16;
   int     tcnt = 0;
   int     cyc = 0;
   int     n_chk = 0;
   int     n_err = 0;
   int     frames_seen = 0;
   bit     mon_en = 0;
   frame_t sb[$];
   int     st_log[$];
   int     dn_log[$];

   uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
      .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(d0), .tx_valid(vld[0]),
      .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(bsy[0]), .tx_done(dne[0]));
   uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
      .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(d1), .tx_valid(vld[1]),
      .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(bsy[1]), .tx_done(dne[1]));
   uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
      .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(d2), .tx_valid(vld[2]),
      .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(bsy[2]), .tx_done(dne[2]));
   uart_tx_serializer #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
      .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(d3), .tx_valid(vld[3]),
      .tx_ready(rdy[3]), .tx(txl[3]), .tx_busy(bsy[3]), .tx_done(dne[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // cycle counter: value k during the cycle following posedge k
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // baud tick: one cycle in every P, driven at the falling edge
   initial begin
      baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         if (tcnt + 1 >= P) tcnt = 0;
         else tcnt++;
         baud_tick = (tcnt == P - 1);
      end
   end

   // reference frame for instance idx
   function automatic frame_t build(input int idx, input logic [8:0] d);
      frame_t f;
      int db, pen, podd, sbits, k, ones;
      case (idx)
         0:       begin db = 8; pen = 0; podd = 0; sbits = 1; end
         1:       begin db = 8; pen = 1; podd = 0; sbits = 1; end
         2:       begin db = 8; pen = 1; podd = 1; sbits = 1; end
         default: begin db = 5; pen = 0; podd = 0; sbits = 2; end
      endcase
      f.idx  = idx;
      f.bits = '0;
      k      = 1;
      ones   = 0;
      for (int i = 0; i < db; i++) begin
         f.bits[k] = d[i];
         if (d[i]) ones++;
         k++;
      end
      if (pen != 0) begin
         f.bits[k] = (podd != 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
         k++;
      end
      for (int s = 0; s < sbits; s++) begin
         f.bits[k] = 1'b1;
         k++;
      end
      f.n = k;
      return f;
   endfunction

   task automatic set_in(input int idx, input logic [8:0] d, input logic v);
      case (idx)
         0:       d0 = d[7:0];
         1:       d1 = d[7:0];
         2:       d2 = d[7:0];
         default: d3 = d[4:0];
      endcase
      vld[idx] = v;
   endtask

   // one-cycle valid pulse; scrambles tx_data right after the accept edge
   task automatic send(input int idx, input logic [8:0] d, input bit push);
      int w = 0;
      @(negedge clk);
      while (rdy[idx] !== 1'b1 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      set_in(idx, d, 1'b1);
      if (push) sb.push_back(build(idx, d));
      @(posedge clk);
      #1;
      set_in(idx, ~d, 1'b0);
   endtask

   task automatic wait_frames(input int target);
      int w = 0;
      while (frames_seen < target && w < 4000) begin
         @(negedge clk);
         w++;
      end
   endtask

   // line monitor / scoreboard consumer
   initial begin
      frame_t f;
      int     idx;
      logic   got0, got1;
      bit     bad, unexp_rep;
      unexp_rep = 0;
      forever begin
         @(negedge clk);
         if (mon_en && sb.size() > 0) begin
            idx = sb[0].idx;
            if (txl[idx] === 1'b0) begin
               f = sb.pop_front();
               st_log.push_back(cyc);
               bad  = 0;
               got0 = 1'bx;
               got1 = 1'bx;
               for (int i = 0; i < f.n; i++) begin
                  for (int j = 0; j < P; j++) begin
                     if (j == 0) got0 = txl[idx];
                     if (j == P - 1) got1 = txl[idx];
                     if (rdy[idx] !== 1'b0 || bsy[idx] !== 1'b1 || dne[idx] !== 1'b0) bad = 1;
                     @(negedge clk);
                  end
                  n_chk++;
                  if (got0 !== f.bits[i] || got1 !== f.bits[i]) begin
                     n_err++;
                     $display("FAIL line_bit dut%0d bit%0d: got %b/%b (first/last cycle), expected %b",
                              idx, i, got0, got1, f.bits[i]);
                  end
               end
               n_chk++;
               if (bad) begin
                  n_err++;
                  $display("FAIL frame_ctrl dut%0d: ready/busy/done not 0/1/0 throughout frame", idx);
               end
               dn_log.push_back(cyc);
               n_chk++;
               if (dne[idx] !== 1'b1 || rdy[idx] !== 1'b1 || bsy[idx] !== 1'b0) begin
                  n_err++;
                  $display("FAIL done_cycle dut%0d: done=%b ready=%b busy=%b, expected 1 1 0",
                           idx, dne[idx], rdy[idx], bsy[idx]);
               end
               @(negedge clk);
               n_chk++;
               if (dne[idx] !== 1'b0) begin
                  n_err++;
                  $display("FAIL done_width dut%0d: done=%b one cycle later, expected 0", idx, dne[idx]);
               end
               frames_seen++;
            end
         end else if (mon_en && txl !== 4'hF && !unexp_rep) begin
            unexp_rep = 1;
            n_chk++;
            n_err++;
            $display("FAIL idle_line: tx=%b with no frame pending, expected 1111", txl);
         end
      end
   end

   task automatic test_reset();
      reset_n = 1'b0;
      vld     = 4'h0;
      d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      repeat (3) @(negedge clk);
      n_chk++; if (txl !== 4'hF) begin n_err++; $display("FAIL reset_tx: got %b expected 1111", txl); end
      n_chk++; if (rdy !== 4'hF) begin n_err++; $display("FAIL reset_ready: got %b expected 1111", rdy); end
      n_chk++; if (bsy !== 4'h0) begin n_err++; $display("FAIL reset_busy: got %b expected 0000", bsy); end
      n_chk++; if (dne !== 4'h0) begin n_err++; $display("FAIL reset_done: got %b expected 0000", dne); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1;
   endtask

   task automatic test_basic();
      int base = frames_seen;
      P = 16;
      send(0, 9'h0A5, 1);
      wait_frames(base + 1);
      n_chk++;
      if (frames_seen != base + 1) begin
         n_err++; $display("FAIL basic_frame: frames seen %0d expected %0d", frames_seen, base + 1);
      end else begin
         n_chk++;
         if (dn_log[$] - st_log[$] != 10 * 16) begin
            n_err++; $display("FAIL basic_len: %0d clk start-to-done expected %0d", dn_log[$] - st_log[$], 160);
         end
      end
   endtask

   task automatic test_parity();
      int base = frames_seen;
      P = 16;
      send(1, 9'h0A5, 1);
      wait_frames(base + 1);
      n_chk++;
      if (frames_seen != base + 1) begin
         n_err++; $display("FAIL even_par_frame: frames seen %0d expected %0d", frames_seen, base + 1);
      end else begin
         n_chk++;
         if (dn_log[$] - st_log[$] != 11 * 16) begin
            n_err++; $display("FAIL even_par_len: %0d clk expected %0d", dn_log[$] - st_log[$], 176);
         end
      end
      // odd parity with baud_tick held high (one bit per clk)
      P = 1;
      send(2, 9'h007, 1);
      wait_frames(base + 2);
      n_chk++;
      if (frames_seen != base + 2) begin
         n_err++; $display("FAIL odd_par_frame: frames seen %0d expected %0d", frames_seen, base + 2);
      end else begin
         n_chk++;
         if (dn_log[$] - st_log[$] != 11) begin
            n_err++; $display("FAIL odd_par_len: %0d clk expected 11", dn_log[$] - st_log[$]);
         end
      end
      P = 16;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_stop2();
      int base = frames_seen;
      P = 16;
      send(3, 9'h013, 1);
      wait_frames(base + 1);
      n_chk++;
      if (frames_seen != base + 1) begin
         n_err++; $display("FAIL stop2_frame: frames seen %0d expected %0d", frames_seen, base + 1);
      end else begin
         n_chk++;
         if (dn_log[$] - st_log[$] != 8 * 16) begin
            n_err++; $display("FAIL stop2_len: %0d clk expected %0d", dn_log[$] - st_log[$], 128);
         end
      end
   endtask

   task automatic test_reset_mid();
      int w = 0;
      bit bad = 0;
      P = 16;
      mon_en = 0;
      send(0, 9'h0A5, 0);
      while (txl[0] !== 1'b0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      n_chk++;
      if (txl[0] !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_start: tx=%b expected 0 (start bit)", txl[0]);
      end
      repeat (3 * 16 + 5) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      n_chk++; if (txl[0] !== 1'b1) begin n_err++; $display("FAIL rst_mid_tx: got %b expected 1", txl[0]); end
      n_chk++; if (rdy[0] !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b expected 1", rdy[0]); end
      n_chk++; if (bsy[0] !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", bsy[0]); end
      n_chk++; if (dne[0] !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b expected 0", dne[0]); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      mon_en  = 1;
      repeat (40 * 16) begin
         @(negedge clk);
         if (txl[0] !== 1'b1 || rdy[0] !== 1'b1) bad = 1;
      end
      n_chk++;
      if (bad) begin n_err++; $display("FAIL rst_mid_quiet: line/ready left idle after reset, expected tx=1 ready=1"); end
   endtask

   task automatic test_back_to_back();
      int base = frames_seen;
      int acc, w, ns;
      P = 16;
      // line up valid with a tick so the tick lands in the accept cycle
      do begin
         @(negedge clk);
         #1;
      end while (baud_tick !== 1'b1);
      set_in(0, 9'h055, 1'b1);
      sb.push_back(build(0, 9'h055));
      sb.push_back(build(0, 9'h0AA));
      @(posedge clk);
      #1;
      acc = cyc;
      n_chk++;
      if (rdy[0] !== 1'b0) begin n_err++; $display("FAIL b2b_accept1: ready=%b expected 0", rdy[0]); end
      set_in(0, 9'h0AA, 1'b1);
      w = 0;
      @(negedge clk);
      while (dne[0] !== 1'b1 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (rdy[0] !== 1'b0) begin n_err++; $display("FAIL b2b_accept2: ready=%b expected 0", rdy[0]); end
      set_in(0, 9'h000, 1'b0);
      wait_frames(base + 2);
      n_chk++;
      if (frames_seen != base + 2) begin
         n_err++; $display("FAIL b2b_frames: frames seen %0d expected %0d", frames_seen, base + 2);
      end else begin
         ns = st_log.size();
         n_chk++;
         if (st_log[ns-2] != acc + 16) begin
            n_err++; $display("FAIL b2b_tick_ignored: start at cycle %0d expected %0d", st_log[ns-2], acc + 16);
         end
         n_chk++;
         if (st_log[ns-1] != dn_log[ns-2] + 16) begin
            n_err++; $display("FAIL b2b_gap: second start at cycle %0d expected %0d", st_log[ns-1], dn_log[ns-2] + 16);
         end
      end
   endtask

   task automatic test_stall();
      int base = frames_seen;
      bit bad = 0;
      P = 16;
      set_in(0, 9'h0FF, 1'b0);
      repeat (100 * 16) begin
         @(negedge clk);
         if (txl[0] !== 1'b1 || rdy[0] !== 1'b1) bad = 1;
      end
      n_chk++;
      if (bad) begin n_err++; $display("FAIL stall_idle: line not held idle during stall"); end
      send(0, 9'h03C, 1);
      n_chk++;
      if (rdy[0] !== 1'b0) begin n_err++; $display("FAIL stall_accept: ready=%b after first valid edge, expected 0", rdy[0]); end
      wait_frames(base + 1);
      n_chk++;
      if (frames_seen != base + 1) begin
         n_err++; $display("FAIL stall_frame: frames seen %0d expected %0d", frames_seen, base + 1);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_stop2();
      test_reset_mid();
      test_back_to_back();
      test_stall();
      repeat (20) @(negedge clk);
      n_chk++;
      if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left: %0d frames never seen", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
